// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Owns the FENCE.I drain/invalidate/refetch flow and the perf counters.
module pipeline_hazard_ctrl #(
  parameter int FENCE_DRAIN_CYCLES = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hazard,
  input  logic             icache_ready,
  input  logic             dcache_stall,
  input  logic             redirect_valid,
  input  logic             fence_i_id,
  input  logic             icache_inval_done,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_valid_in,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             icache_inval,
  output logic             fence_redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW =
    (FENCE_DRAIN_CYCLES > 1) ? $clog2(FENCE_DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD =
    DW'(FENCE_DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    INVAL,
    REFETCH
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            inval_d;
  logic            fredir_d;
  logic            flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      icache_inval   <= 1'b0;
      fence_redirect <= 1'b0;
      stall_q        <= '0;
      flush_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      icache_inval   <= inval_d;
      fence_redirect <= fredir_d;
      if (!pc_enable)
        stall_q <= stall_q + 1'b1;
      if (flush_inc)
        flush_q <= flush_q + 1'b1;
    end
  end

  always_comb begin
    pc_enable      = 1'b1;
    if_id_enable   = 1'b1;
    if_id_valid_in = 1'b1;
    id_ex_enable   = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_enable  = 1'b1;
    state_d        = state_q;
    cnt_d          = cnt_q;
    inval_d        = 1'b0;
    fredir_d       = 1'b0;
    flush_inc      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dcache_stall) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
        end else if (redirect_valid) begin
          if_id_valid_in = 1'b0;
          id_ex_flush    = 1'b1;
          flush_inc      = 1'b1;
        end else if (fence_i_id) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          cnt_d        = DRAIN_LOAD;
          state_d      = DRAIN;
        end else if (load_use_hazard) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
        end else if (!icache_ready) begin
          pc_enable      = 1'b0;
          if_id_valid_in = 1'b0;
        end
      end
      DRAIN: begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_flush   = !dcache_stall;
        id_ex_enable  = !dcache_stall;
        ex_mem_enable = !dcache_stall;
        if (!dcache_stall) begin
          if (cnt_q == '0) begin
            inval_d = 1'b1;
            state_d = INVAL;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      INVAL: begin
        // a late store may still be stuck in MEM; keep it frozen
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_flush   = !dcache_stall;
        id_ex_enable  = !dcache_stall;
        ex_mem_enable = !dcache_stall;
        if (icache_inval_done) begin
          fredir_d  = 1'b1;
          flush_inc = 1'b1;
          state_d   = REFETCH;
        end
      end
      REFETCH: begin
        if_id_valid_in = 1'b0;
        id_ex_flush    = 1'b1;
        state_d        = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipeline_hazard_ctrl.
// Stimulus queues expectations; a negedge monitor compares.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        load_use_hazard;
  logic        icache_ready;
  logic        dcache_stall;
  logic        redirect_valid;
  logic        fence_i_id;
  logic        icache_inval_done;
  logic        pc_enable;
  logic        if_id_enable;
  logic        if_id_valid_in;
  logic        id_ex_enable;
  logic        id_ex_flush;
  logic        ex_mem_enable;
  logic        icache_inval;
  logic        fence_redirect;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  pipeline_hazard_ctrl #(
    .FENCE_DRAIN_CYCLES(3),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_use_hazard(load_use_hazard),
    .icache_ready(icache_ready),
    .dcache_stall(dcache_stall),
    .redirect_valid(redirect_valid),
    .fence_i_id(fence_i_id),
    .icache_inval_done(icache_inval_done),
    .pc_enable(pc_enable),
    .if_id_enable(if_id_enable),
    .if_id_valid_in(if_id_valid_in),
    .id_ex_enable(id_ex_enable),
    .id_ex_flush(id_ex_flush),
    .ex_mem_enable(ex_mem_enable),
    .icache_inval(icache_inval),
    .fence_redirect(fence_redirect),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  typedef struct {
    string       name;
    logic [7:0]  outs;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // {pc, if_id, valid_in, id_ex, flush, ex_mem, inval, fence_redirect}
  localparam logic [7:0] IDLE = 8'b1111_0100;
  localparam logic [7:0] LU   = 8'b0011_1100;
  localparam logic [7:0] IMIS = 8'b0101_0100;
  localparam logic [7:0] RDIR = 8'b1101_1100;
  localparam logic [7:0] FRZ  = 8'b0010_0000;
  localparam logic [7:0] HOLD = 8'b0011_1100;
  localparam logic [7:0] INVP = 8'b0011_1110;
  localparam logic [7:0] REF  = 8'b1101_1101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {pc_enable, if_id_enable, if_id_valid_in, id_ex_enable,
             id_ex_flush, ex_mem_enable, icache_inval, fence_redirect};
      checks++;
      if (act !== e.outs || stall_cycles !== e.sc ||
          flush_count !== e.fc) begin
        failures++;
        $display("FAIL %s: got outs=%b sc=%0d fc=%0d want outs=%b sc=%0d fc=%0d",
                 e.name, act, stall_cycles, flush_count,
                 e.outs, e.sc, e.fc);
      end
    end
  end

  task automatic cyc(input string nm, input logic r,
                     input logic lu, input logic icr,
                     input logic ds, input logic rv,
                     input logic fi, input logic dn,
                     input logic [7:0] o,
                     input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    rst               = r;
    load_use_hazard   = lu;
    icache_ready      = icr;
    dcache_stall      = ds;
    redirect_valid    = rv;
    fence_i_id        = fi;
    icache_inval_done = dn;
    e.name = nm;
    e.outs = o;
    e.sc   = sc;
    e.fc   = fc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_use_hazard = 1'b0;
    icache_ready = 1'b1;
    dcache_stall = 1'b0;
    redirect_valid = 1'b0;
    fence_i_id = 1'b0;
    icache_inval_done = 1'b0;
    @(posedge clk);
    #1;
    //          name       rst lu icr ds rv fi dn outs  sc  fc
    cyc("reset",      1, 0, 1, 0, 0, 0, 0, IDLE,  0, 0);
    cyc("idle",       0, 0, 1, 0, 0, 0, 0, IDLE,  0, 0);
    cyc("load_use",   0, 1, 1, 0, 0, 0, 0, LU,    0, 0);
    cyc("lu_after",   0, 0, 1, 0, 0, 0, 0, IDLE,  1, 0);
    for (int i = 0; i < 4; i++)
      cyc("imiss",    0, 0, 0, 0, 0, 0, 0, IMIS, 32'(1 + i), 0);
    cyc("imiss_end",  0, 0, 1, 0, 0, 0, 0, IDLE,  5, 0);
    cyc("redir_all",  0, 1, 0, 0, 1, 0, 0, RDIR,  5, 0);
    cyc("redir_cnt",  0, 0, 1, 0, 0, 0, 0, IDLE,  5, 1);
    for (int i = 0; i < 3; i++)
      cyc("dstall_rd",0, 0, 1, 1, 1, 0, 0, FRZ,  32'(5 + i), 1);
    cyc("redir_late", 0, 0, 1, 0, 1, 0, 0, RDIR,  8, 1);
    cyc("redir_cnt2", 0, 0, 1, 0, 0, 0, 0, IDLE,  8, 2);
    cyc("lu_imiss",   0, 1, 0, 0, 0, 0, 0, LU,    8, 2);
    cyc("lu_imiss2",  0, 0, 1, 0, 0, 0, 0, IDLE,  9, 2);
    cyc("fence_id",   0, 0, 1, 0, 0, 1, 0, HOLD,  9, 2);
    cyc("drain2",     0, 0, 1, 0, 0, 0, 0, HOLD, 10, 2);
    cyc("drain_frz",  0, 0, 1, 1, 0, 0, 0, FRZ,  11, 2);
    cyc("drain1",     0, 0, 1, 0, 0, 0, 0, HOLD, 12, 2);
    cyc("drain0",     0, 0, 1, 0, 0, 0, 0, HOLD, 13, 2);
    cyc("inval_pls",  0, 0, 1, 0, 0, 0, 0, INVP, 14, 2);
    cyc("inval_wt",   0, 0, 1, 0, 0, 0, 0, HOLD, 15, 2);
    cyc("inval_done", 0, 0, 1, 0, 0, 0, 1, HOLD, 16, 2);
    cyc("refetch",    0, 0, 1, 0, 0, 0, 0, REF,  17, 3);
    cyc("fence_run",  0, 0, 1, 0, 0, 0, 0, IDLE, 17, 3);
    cyc("fence2_id",  0, 0, 1, 0, 0, 1, 0, HOLD, 17, 3);
    cyc("f2_drain2",  0, 0, 1, 0, 0, 0, 0, HOLD, 18, 3);
    cyc("f2_drain1",  0, 0, 1, 0, 0, 0, 0, HOLD, 19, 3);
    cyc("rst_drain",  1, 0, 1, 0, 0, 0, 0, IDLE,  0, 0);
    cyc("rst_hold",   1, 0, 1, 0, 0, 0, 0, IDLE,  0, 0);
    for (int i = 0; i < 4; i++)
      cyc("post_rst", 0, 0, 1, 0, 0, 0, 0, IDLE,  0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and valid-kill controls of the PC register, IF/ID and ID/EX pipeline registers, based on load-use hazards, I-cache/D-cache misses, branch redirects and FENCE.I. Contains a small FSM for multi-cycle events and two performance counters. Sits beside the pipeline registers in the core top level.

Parameters:
FENCE_DRAIN_CYCLES, 3, bubble cycles inserted before I-cache invalidate so older instructions retire
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
load_use_hazard  in  1  ID instr needs rd of a load currently in EX
icache_ready  in  1  fetch data valid this cycle
dcache_stall  in  1  MEM-stage access not complete
redirect_valid  in  1  taken branch/jump resolved in EX
fence_i_id  in  1  valid FENCE.I in ID
icache_inval_done  in  1  invalidate complete (single-cycle pulse)
pc_enable  out  1  PC register load enable
if_id_enable  out  1  IF/ID register enable
if_id_valid_in  out  1  valid bit written into IF/ID (0 = bubble)
id_ex_enable  out  1  ID/EX register enable
id_ex_flush  out  1  write bubble into ID/EX
ex_mem_enable  out  1  EX/MEM and MEM/WB enable
icache_inval  out  1  invalidate request, one-cycle pulse
fence_redirect  out  1  one-cycle request to refetch from FENCE.I pc+4
stall_cycles  out  CNT_W  cycles with pc_enable=0
flush_count  out  CNT_W  number of redirect or fence flush events

Behaviour:
- Reset (async, rst=1): state=RUN, drain counter=0, counters=0, icache_inval=0, fence_redirect=0; enable outputs are all 1, if_id_valid_in=1, id_ex_flush=0 (pipe free-running after reset).
- Enables/flush are combinational from state and inputs (same-cycle effect); state, counters, icache_inval, fence_redirect are registered on posedge clk.
- States: RUN, DRAIN, INVAL, REFETCH.
- RUN priority, highest first:
  1 dcache_stall: all enables 0 (whole pipe frozen), no flush; redirect ignored this cycle and acted on when stall drops (EX holds it).
  2 redirect_valid: pc_enable=1, if_id_enable=1, if_id_valid_in=0, id_ex_flush=1 (kills IF and ID); flush_count+1. Overrides icache miss, load-use and fence_i_id.
  3 fence_i_id: pc_enable=0, if_id_enable=0, id_ex_flush=1; drain counter loaded with FENCE_DRAIN_CYCLES-1; next=DRAIN.
  4 load_use_hazard: pc_enable=0, if_id_enable=0, id_ex_flush=1, ex_mem_enable=1 (one bubble).
  5 !icache_ready: pc_enable=0, if_id_enable=1, if_id_valid_in=0 (bubble into ID), rest of pipe runs.
  If 4 and 5 both hold: load-use response, if_id_enable=0 (ID instruction retained).
- DRAIN: pc/if_id held, id_ex_flush=1, later stages run; dcache_stall freezes counter and later stages. Counter 0 -> assert icache_inval next cycle, go INVAL.
- INVAL: pc/if_id held, id_ex_flush=1; on icache_inval_done -> pulse fence_redirect, flush_count+1, go REFETCH.
- REFETCH: one cycle, if_id_valid_in=0, id_ex_flush=1, pc_enable=1; -> RUN.
- stall_cycles increments every cycle pc_enable=0; both counters wrap at 2^CNT_W.
- redirect_valid outside RUN is ignored (cannot occur: EX is bubbles).

Test Plan:
- Reset mid-DRAIN (rst at drain counter=1) -> state RUN, all enables 1, counters 0, icache_inval never pulses.
- load_use_hazard one cycle -> pc_enable=0, if_id_enable=0, id_ex_flush=1 that cycle only; stall_cycles=1.
- icache_ready low 4 cycles -> if_id_valid_in=0, pc_enable=0 for 4 cycles, id_ex_enable=1; stall_cycles=4.
- redirect_valid with load_use_hazard and !icache_ready same cycle -> pc_enable=1, if_id_valid_in=0, id_ex_flush=1, flush_count=1.
- dcache_stall 3 cycles overlapping redirect_valid -> all enables 0 for 3 cycles; flush on cycle after stall clears.
- fence_i_id, DRAIN_CYCLES=3, icache_inval_done 2 cycles after pulse -> 3 drain cycles, icache_inval 1-cycle pulse, fence_redirect pulse, flush_count=1, back to RUN.
